// File: rtl/ddr_read_ctrl_pkg.sv
// Shared types and constants for the DDR read-side controller.
package ddr_rd_pkg;

    // Default widths: halfword address, one DDR burst line, one halfword.
    localparam int ADDR_W_DEF = 27;
    localparam int LINE_W_DEF = 128;
    localparam int DATA_W_DEF = 16;

    // Halfword index bits inside a line (8 halfwords per line).
    localparam int HW_SEL_W = 3;

    // DDR application interface read command.
    localparam logic [2:0] CMD_READ = 3'b001;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/ddr_line_sel.sv
// Combinational halfword selector: picks halfword idx out of a line.
module ddr_line_sel
    import ddr_rd_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [LINE_W-1:0]   line,
    input  logic [HW_SEL_W-1:0] idx,
    output logic [DATA_W-1:0]   hw
);

    localparam int NUM_HW = LINE_W / DATA_W;

    // Line viewed as halfword lanes; lane n is bits [DATA_W*n +: DATA_W].
    logic [NUM_HW-1:0][DATA_W-1:0] lanes;

    assign lanes = line;

    // Plain lane mux driven by the halfword index.
    always_comb begin
        hw = lanes[idx];
    end

endmodule

// File: rtl/ddr_read_ctrl.sv
// Read-side controller: arbitrates two halfword read ports, keeps one tagged
// line buffer and fetches whole lines from the DDR application interface.
module ddr_read_ctrl
    import ddr_rd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    // CPU-side ports: 0 = instruction fetch, 1 = data
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ready,
    output logic [DATA_W-1:0] p0_data,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_ready,
    output logic [DATA_W-1:0] p1_data,
    // line buffer invalidate
    input  logic              inv,
    // DDR controller application interface
    input  logic              init_calib_complete,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    input  logic [LINE_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid
);

    localparam int TAG_W = ADDR_W - HW_SEL_W;

    rd_state_t state, state_nxt;

    // Ports gathered into packed arrays so the arbiter can index them.
    logic [1:0]             req;
    logic [1:0][ADDR_W-1:0] addr;

    // Arbitration result for the current cycle.
    logic              gnt_now;
    logic              gnt_port;
    logic [ADDR_W-1:0] gnt_addr;
    logic              hit;
    logic              fill;

    // Latched grant context.
    logic              grant;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;

    // Line buffer.
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_buf;

    // Response path.
    logic [LINE_W-1:0]      sel_line;
    logic [HW_SEL_W-1:0]    sel_idx;
    logic [DATA_W-1:0]      sel_hw;
    logic                   resp_port;
    logic [1:0]             rdy_q;
    logic [1:0][DATA_W-1:0] data_q;

    assign req  = {p1_req, p0_req};
    assign addr = {p1_addr, p0_addr};

    // Round-robin arbiter: on a tie the port that was not served last wins,
    // a lone requester always wins. Grants are blocked until calibration.
    always_comb begin
        gnt_now  = init_calib_complete & (|req);
        gnt_port = (&req) ? ~last_grant : req[1];
        gnt_addr = addr[gnt_port];
        hit      = line_valid && (line_tag == gnt_addr[ADDR_W-1:HW_SEL_W]);
        fill     = (state == WAIT) && app_rd_data_valid;
    end

    // State register; reset abandons any outstanding DDR read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (gnt_now) begin
                    state_nxt = hit ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (app_rdy) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (app_rd_data_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch grant context in IDLE; app_addr is derived from it, so it stays
    // stable for the whole ISSUE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
        end else if (state == IDLE && gnt_now) begin
            grant      <= gnt_port;
            last_grant <= gnt_port;
            addr_q     <= gnt_addr;
        end
    end

    // Line buffer fill. inv wins over a same-cycle fill for line_valid only;
    // the captured line still feeds the pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= 1'b0;
            line_tag   <= '0;
            line_buf   <= '0;
        end else begin
            if (fill) begin
                line_buf <= app_rd_data;
                line_tag <= addr_q[ADDR_W-1:HW_SEL_W];
            end
            if (inv) begin
                line_valid <= 1'b0;
            end else if (fill) begin
                line_valid <= 1'b1;
            end
        end
    end

    // Selector source: the incoming line during a fill, the buffer on a hit.
    always_comb begin
        sel_line  = (state == WAIT) ? app_rd_data : line_buf;
        sel_idx   = (state == IDLE) ? gnt_addr[HW_SEL_W-1:0] : addr_q[HW_SEL_W-1:0];
        resp_port = (state == IDLE) ? gnt_port : grant;
    end

    ddr_line_sel #(
        .LINE_W (LINE_W),
        .DATA_W (DATA_W)
    ) u_line_sel (
        .line (sel_line),
        .idx  (sel_idx),
        .hw   (sel_hw)
    );

    // Registered responses: ready pulses in the RESP cycle, data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q  <= '0;
            data_q <= '0;
        end else begin
            rdy_q <= '0;
            if (state_nxt == RESP) begin
                rdy_q[resp_port]  <= 1'b1;
                data_q[resp_port] <= sel_hw;
            end
        end
    end

    assign p0_ready = rdy_q[0];
    assign p1_ready = rdy_q[1];
    assign p0_data  = data_q[0];
    assign p1_data  = data_q[1];

    assign app_en   = (state == ISSUE);
    assign app_cmd  = CMD_READ;
    assign app_addr = {addr_q[ADDR_W-1:HW_SEL_W], {HW_SEL_W{1'b0}}};

endmodule
